// File: rtl/univ_shift_reg.sv
// univ_shift_reg -- WIDTH-bit universal shift register.
//   Holds, shifts, rotates, parallel-loads or sync-clears a D-flip-flop bank.
//   A saturating counter tracks shifts since the last load/clear, and
//   word_done_o pulses on the shift that completes a full word.
//
// Optional feature: define USR_ARITH_SHIFT_EN to make mode 3'b111 an
// arithmetic shift right (counts as a shift). Without it, 3'b111 holds.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   en_i         operation enable (0 -> hold everything, word_done_o=0)
//   mode_i[2:0]  000 hold, 001 shl, 010 shr, 011 rol, 100 ror,
//                101 load, 110 clear, 111 asr/hold
//   din_i        parallel load data
//   sin_lsb_i    serial in to q[0] on shift left
//   sin_msb_i    serial in to q[WIDTH-1] on shift right
//   q_o          register contents
//   sout_msb_o   q[WIDTH-1]
//   sout_lsb_o   q[0]
//   shift_cnt_o  shifts since last load/clear, saturating at WIDTH
//   word_done_o  one-cycle pulse when shift_cnt_o reaches WIDTH
module univ_shift_reg #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  localparam int                CW      = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             sin_lsb_i,
  input  logic             sin_msb_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_msb_o,
  output logic             sout_lsb_o,
  output logic [CW-1:0]    shift_cnt_o,
  output logic             word_done_o
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHL   = 3'b001,
    M_SHR   = 3'b010,
    M_ROL   = 3'b011,
    M_ROR   = 3'b100,
    M_LOAD  = 3'b101,
    M_CLEAR = 3'b110,
    M_EXT   = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wd_q, wd_d;
  logic             is_shift;

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    is_shift = 1'b0;
    if (en_i) begin
      case (mode_e'(mode_i))
        M_SHL:   begin q_d = {q_q[WIDTH-2:0], sin_lsb_i};  is_shift = 1'b1; end
        M_SHR:   begin q_d = {sin_msb_i, q_q[WIDTH-1:1]};  is_shift = 1'b1; end
        M_ROL:   begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; is_shift = 1'b1; end
        M_ROR:   begin q_d = {q_q[0], q_q[WIDTH-1:1]};     is_shift = 1'b1; end
        M_LOAD:  begin q_d = din_i;   cnt_d = '0; end
        M_CLEAR: begin q_d = RST_VAL; cnt_d = '0; end
`ifdef USR_ARITH_SHIFT_EN
        M_EXT:   begin q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; is_shift = 1'b1; end
`else
        M_EXT:   ;
`endif
        default: ;
      endcase
    end
    // Saturating count; the pulse fires only on the step from WIDTH-1 to WIDTH,
    // so further shifts while saturated stay quiet until a load/clear re-arms.
    if (is_shift && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    wd_d = is_shift && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= RST_VAL;
      cnt_q <= '0;
      wd_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      wd_q  <= wd_d;
    end
  end

  assign q_o         = q_q;
  assign sout_msb_o  = q_q[WIDTH-1];
  assign sout_lsb_o  = q_q[0];
  assign shift_cnt_o = cnt_q;
  assign word_done_o = wd_q;

endmodule
